parking_entry_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer sharing the car-park slot pool between NUM_LANES entry lanes.

---
 rtl/parking_entry_arbiter.sv | 132 +++++++++++++
 tb/tb_parking_entry_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/parking_entry_arbiter.sv
// Round-robin entry-lane arbiter for a shared car-park slot pool: grants one lane,
// holds its gate open until the car passes, backs away or times out, then cools down.
//
// state  | meaning
// IDLE   | waiting for a request while free slots remain
// GRANT  | granted lane's gate open, waiting for pass / back-away / timeout
// COMMIT | one-cycle slot allocation pulse to the slot counter
// COOL   | all gates closed so the updated slot count settles before the next grant
module parking_entry_arbiter #(
  parameter int NUM_LANES    = 4,
  parameter int OPEN_TIMEOUT = 10,
  parameter int COOLDOWN     = 2
) (
  input  logic                 clk_1Hz_i,
  input  logic                 reset_i,
  input  logic [NUM_LANES-1:0] lane_req_i,
  input  logic [NUM_LANES-1:0] lane_pass_i,
  input  logic [3:0]           remaining_slots_i,
  output logic [NUM_LANES-1:0] gate_open_o,
  output logic [1:0]           grant_lane_o,
  output logic                 busy_o,
  output logic                 commit_o,
  output logic                 timeout_evt_o,
  output logic                 full_lamp_o
);

  localparam int TMAX = (OPEN_TIMEOUT > COOLDOWN) ? OPEN_TIMEOUT : COOLDOWN;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] T_OPEN = TW'(OPEN_TIMEOUT - 1);
  localparam logic [TW-1:0] T_COOL = TW'(COOLDOWN - 1);

  typedef enum logic [1:0] {IDLE, GRANT, COMMIT, COOL} state_t;

  state_t               state_q;
  logic [TW-1:0]        timer_q;
  logic [1:0]           rr_q, grant_q;
  logic [NUM_LANES-1:0] gate_q;
  logic                 busy_q, commit_q, timeout_q;

  logic [1:0]           sel_d, rr_d, lane_idx;
  logic                 found_d;
  logic [NUM_LANES-1:0] sel_oh_d;
  int                   idx;

  // Search starts at the round-robin pointer and wraps modulo NUM_LANES.
  always_comb begin
    sel_d    = rr_q;
    found_d  = 1'b0;
    idx      = 0;
    lane_idx = 2'd0;
    for (int k = 0; k < NUM_LANES; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      lane_idx = 2'(idx);
      if (!found_d && lane_req_i[lane_idx]) begin
        sel_d   = lane_idx;
        found_d = 1'b1;
      end
    end
    sel_oh_d        = '0;
    sel_oh_d[sel_d] = 1'b1;
    rr_d            = (int'(sel_d) == NUM_LANES - 1) ? 2'd0 : sel_d + 2'd1;
  end

  always_ff @(posedge clk_1Hz_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      rr_q      <= 2'd0;
      grant_q   <= 2'd0;
      gate_q    <= '0;
      busy_q    <= 1'b0;
      commit_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      commit_q  <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found_d && remaining_slots_i != 4'd0) begin
            state_q <= GRANT;
            gate_q  <= sel_oh_d;
            grant_q <= sel_d;
            rr_q    <= rr_d;
            timer_q <= T_OPEN;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          // Pass outranks timeout so a car clearing on the last open cycle is still counted.
          if (lane_pass_i[grant_q]) begin
            state_q  <= COMMIT;
            gate_q   <= '0;
            commit_q <= 1'b1;
          end else if (!lane_req_i[grant_q]) begin
            state_q <= COOL;
            gate_q  <= '0;
            timer_q <= T_COOL;
          end else if (timer_q == '0) begin
            state_q   <= COOL;
            gate_q    <= '0;
            timeout_q <= 1'b1;
            timer_q   <= T_COOL;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        COMMIT: begin
          state_q <= COOL;
          timer_q <= T_COOL;
        end
        COOL: begin
          if (timer_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gate_open_o   = gate_q;
  assign grant_lane_o  = grant_q;
  assign busy_o        = busy_q;
  assign commit_o      = commit_q;
  assign timeout_evt_o = timeout_q;
  assign full_lamp_o   = (remaining_slots_i == 4'd0);

endmodule

// File: tb/tb_parking_entry_arbiter.sv
// Directed bench for parking_entry_arbiter: grant latency, round robin, timeout,
// full-pool blocking, pass/timeout priority and asynchronous reset mid-grant.
module tb_parking_entry_arbiter;

  logic       clk_1Hz, reset;
  logic [3:0] lane_req, lane_pass, remaining_slots;
  logic [3:0] gate_open;
  logic [1:0] grant_lane;
  logic       busy, commit, timeout_evt, full_lamp;

  int checks = 0;
  int errors = 0;
  int commit_cnt = 0;

  parking_entry_arbiter dut (
    .clk_1Hz_i        (clk_1Hz),
    .reset_i          (reset),
    .lane_req_i       (lane_req),
    .lane_pass_i      (lane_pass),
    .remaining_slots_i(remaining_slots),
    .gate_open_o      (gate_open),
    .grant_lane_o     (grant_lane),
    .busy_o           (busy),
    .commit_o         (commit),
    .timeout_evt_o    (timeout_evt),
    .full_lamp_o      (full_lamp)
  );

  initial clk_1Hz = 1'b0;
  always #5 clk_1Hz = ~clk_1Hz;

  always @(negedge clk_1Hz) if (commit) commit_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_1Hz);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    chk("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  logic [1:0] rr_order [4] = '{2'd0, 2'd1, 2'd3, 2'd0};

  initial begin
    reset = 1'b1;
    lane_req = 4'b0000;
    lane_pass = 4'b0000;
    remaining_slots = 4'd9;
    step();
    reset = 1'b0;
    chk("rst_gate", gate_open, 4'b0000);
    chk("rst_grant", grant_lane, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_commit", commit, 1'b0);
    chk("rst_timeout", timeout_evt, 1'b0);

    // single grant and pass on lane 0
    lane_req = 4'b0001;
    step();
    chk("t1_gate", gate_open, 4'b0001);
    chk("t1_grant", grant_lane, 2'd0);
    chk("t1_busy", busy, 1'b1);
    lane_pass = 4'b0001;
    step();
    lane_pass = 4'b0000;
    lane_req = 4'b0000;
    chk("t1_commit", commit, 1'b1);
    chk("t1_gate_closed", gate_open, 4'b0000);
    step();
    chk("t1_commit_once", commit, 1'b0);
    chk("t1_cool1_busy", busy, 1'b1);
    step();
    chk("t1_cool2_busy", busy, 1'b1);
    step();
    chk("t1_idle", busy, 1'b0);

    // round robin over lanes 0,1,3 from a fresh pointer
    do_reset();
    commit_cnt = 0;
    lane_req = 4'b1011;
    for (int g = 0; g < 4; g++) begin
      int n = 0;
      while (gate_open == 4'b0000 && n < 20) begin
        step();
        n++;
      end
      chk("t2_grant", grant_lane, rr_order[g]);
      chk("t2_gate", gate_open, 4'b0001 << rr_order[g]);
      lane_pass = 4'b0001 << rr_order[g];
      step();
      lane_pass = 4'b0000;
      chk("t2_commit", commit, 1'b1);
    end
    lane_req = 4'b0000;
    wait_idle();
    chk("t2_commit_total", commit_cnt, 4);

    // timeout on lane 2
    commit_cnt = 0;
    lane_req = 4'b0100;
    step();
    chk("t3_gate", gate_open, 4'b0100);
    for (int i = 0; i < 9; i++) begin
      step();
      chk("t3_gate_held", gate_open, 4'b0100);
      chk("t3_no_timeout_yet", timeout_evt, 1'b0);
    end
    step();
    lane_req = 4'b0000;
    chk("t3_timeout", timeout_evt, 1'b1);
    chk("t3_gate_closed", gate_open, 4'b0000);
    step();
    chk("t3_timeout_once", timeout_evt, 1'b0);
    wait_idle();
    chk("t3_no_commit", commit_cnt, 0);

    // full pool blocks all grants; rr pointer now at lane 3
    remaining_slots = 4'd0;
    lane_req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_gate", gate_open, 4'b0000);
      chk("t4_busy", busy, 1'b0);
      chk("t4_full", full_lamp, 1'b1);
    end
    remaining_slots = 4'd1;
    step();
    chk("t4_full_off", full_lamp, 1'b0);
    chk("t4_grant", grant_lane, 2'd3);
    chk("t4_gate_open", gate_open, 4'b1000);
    lane_req = 4'b0000;
    step();
    chk("t4_backaway_gate", gate_open, 4'b0000);
    chk("t4_backaway_commit", commit, 1'b0);
    chk("t4_backaway_timeout", timeout_evt, 1'b0);
    wait_idle();

    // pass coinciding with timeout, plus stray pass on another lane
    remaining_slots = 4'd9;
    lane_req = 4'b0001;
    step();
    chk("t5_gate", gate_open, 4'b0001);
    lane_pass = 4'b0010;
    step();
    lane_pass = 4'b0000;
    chk("t5_stray_gate", gate_open, 4'b0001);
    chk("t5_stray_commit", commit, 1'b0);
    for (int i = 0; i < 8; i++) step();
    chk("t5_still_open", gate_open, 4'b0001);
    lane_pass = 4'b0001;
    step();
    lane_pass = 4'b0000;
    lane_req = 4'b0000;
    chk("t5_commit", commit, 1'b1);
    chk("t5_no_timeout", timeout_evt, 1'b0);
    chk("t5_gate_closed", gate_open, 4'b0000);
    wait_idle();

    // async reset during a grant on lane 2
    lane_req = 4'b0100;
    step();
    chk("t6_gate", gate_open, 4'b0100);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_gate", gate_open, 4'b0000);
    chk("t6_async_commit", commit, 1'b0);
    chk("t6_async_busy", busy, 1'b0);
    step();
    reset = 1'b0;
    lane_req = 4'b1001;
    step();
    chk("t6_rr_reset", grant_lane, 2'd0);
    do_reset();
    lane_req = 4'b0010;
    step();
    chk("t6_lane1_grant", grant_lane, 2'd1);
    chk("t6_lane1_gate", gate_open, 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
